// File: rtl/wb_stream_loader_if.sv
// Byte-stream input and Wishbone write-master signals of wb_stream_loader.
// Directions are named from the loader's side.
interface wb_stream_loader_if;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;

    modport master (
        input  rx_valid_i, rx_data_i, wb_ack_i,
        output rx_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );

    modport slave (
        output rx_valid_i, rx_data_i, wb_ack_i,
        input  rx_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );
endinterface

// File: rtl/wb_stream_loader.sv
// Wishbone master that packs a byte stream big-endian into 32-bit words and
// writes them to consecutive word addresses starting at a programmable base.
module wb_stream_loader #(
    parameter int unsigned ack_timeout = 255,
    parameter int unsigned len_width   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [31:0]          base_adr_i,
    input  logic [len_width-1:0] len_i,
    input  logic                 abort_i,
    wb_stream_loader_if.master   bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [len_width-1:0] words_o
);
    localparam int unsigned TO_W = (ack_timeout > 1) ? $clog2(ack_timeout) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_e;

    state_e               state_q;
    logic [1:0]           byte_idx_q;
    logic [31:0]          dat_q;
    logic [31:0]          adr_q;
    logic [len_width-1:0] len_q;
    logic [len_width-1:0] words_q;
    logic [TO_W-1:0]      to_cnt_q;
    logic                 stb_q;
    logic                 rdy_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            byte_idx_q <= 2'd0;
            dat_q      <= 32'd0;
            adr_q      <= 32'd0;
            len_q      <= '0;
            words_q    <= '0;
            to_cnt_q   <= '0;
            stb_q      <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (abort_i) begin
                // Partial word is dropped; words count is kept for software.
                state_q    <= IDLE;
                byte_idx_q <= 2'd0;
                to_cnt_q   <= '0;
                stb_q      <= 1'b0;
                rdy_q      <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            if (len_i != '0) begin
                                state_q    <= COLLECT;
                                len_q      <= len_i;
                                adr_q      <= base_adr_i & 32'hFFFF_FFFC;
                                words_q    <= '0;
                                byte_idx_q <= 2'd0;
                                rdy_q      <= 1'b1;
                                busy_q     <= 1'b1;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    COLLECT: begin
                        if (bus.rx_valid_i && rdy_q) begin
                            dat_q      <= {dat_q[23:0], bus.rx_data_i};
                            byte_idx_q <= byte_idx_q + 2'd1;
                            if (byte_idx_q == 2'd3) begin
                                state_q  <= WRITE;
                                rdy_q    <= 1'b0;
                                stb_q    <= 1'b1;
                                to_cnt_q <= '0;
                            end
                        end
                    end
                    WRITE: begin
                        if (bus.wb_ack_i) begin
                            stb_q   <= 1'b0;
                            words_q <= words_q + len_width'(1);
                            adr_q   <= adr_q + 32'd4;
                            if (words_q + len_width'(1) == len_q) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= COLLECT;
                                rdy_q   <= 1'b1;
                            end
                        end else if (ack_timeout != 0 &&
                                     to_cnt_q == TO_W'(ack_timeout - 1)) begin
                            state_q <= IDLE;
                            stb_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            to_cnt_q <= to_cnt_q + TO_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.rx_ready_o = rdy_q;
    assign bus.wb_cyc_o   = stb_q;
    assign bus.wb_stb_o   = stb_q;
    assign bus.wb_we_o    = stb_q;
    assign bus.wb_sel_o   = {4{stb_q}};
    assign bus.wb_adr_o   = adr_q;
    assign bus.wb_dat_o   = dat_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign words_o        = words_q;
endmodule

// File: tb/tb_wb_stream_loader.sv
// Self-checking bench for wb_stream_loader: a Wishbone RAM slave with
// configurable ack latency, bus monitors, and a word/address reference model.
module tb_wb_stream_loader;
    typedef logic [7:0] byte_q_t[$];
    typedef struct { logic [31:0] adr; logic [31:0] dat; } wr_t;
    typedef struct {
        logic [31:0] base;
        int          len;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] base_adr_i = 32'd0;
    logic [15:0] len_i = 16'd0;
    logic        abort_i = 1'b0;
    logic        busy_o, done_o, err_o;
    logic [15:0] words_o;

    wb_stream_loader_if bus();

    wb_stream_loader #(.ack_timeout(8), .len_width(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_adr_i(base_adr_i),
        .len_i(len_i), .abort_i(abort_i), .bus(bus),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_o(words_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Slave: RAM with ack delayed by cur_delay cycles, optionally silent.
    logic [31:0] mem [logic [31:0]];
    wr_t         wr_q[$];
    bit          slave_mute = 1'b0;
    bit          slave_rand = 1'b0;
    int          cur_delay = 0;
    int          wait_cnt = 0;

    initial begin
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'd0;
    end

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            bus.wb_ack_i <= 1'b0;
            wait_cnt     <= 0;
        end else if (bus.wb_ack_i) begin
            bus.wb_ack_i <= 1'b0;
            wait_cnt     <= 0;
        end else if (bus.wb_cyc_o && bus.wb_stb_o && !slave_mute) begin
            if (wait_cnt >= cur_delay) begin
                bus.wb_ack_i <= 1'b1;
                mem[bus.wb_adr_o] = bus.wb_dat_o;
                wr_q.push_back('{adr: bus.wb_adr_o, dat: bus.wb_dat_o});
                cur_delay <= slave_rand ? int'($urandom_range(0, 5)) : 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    // Bus monitor, sampled on the falling edge.
    int done_cnt = 0, err_cnt = 0, stb_cyc = 0, busy_cyc = 0;
    int gap_viol = 0, stab_viol = 0, sel_viol = 0;
    bit prev_ack = 1'b0, prev_stb = 1'b0;
    logic [31:0] prev_adr = 32'd0, prev_dat = 32'd0;

    always @(negedge clk) begin
        if (rst_i) begin
            prev_ack = 1'b0;
            prev_stb = 1'b0;
        end else begin
            done_cnt += int'(done_o);
            err_cnt  += int'(err_o);
            stb_cyc  += int'(bus.wb_stb_o);
            busy_cyc += int'(busy_o);
            if (prev_ack && bus.wb_stb_o) gap_viol++;
            if (prev_stb && bus.wb_stb_o && !prev_ack &&
                (bus.wb_adr_o != prev_adr || bus.wb_dat_o != prev_dat)) stab_viol++;
            if (bus.wb_we_o != bus.wb_stb_o || bus.wb_cyc_o != bus.wb_stb_o ||
                bus.wb_sel_o != (bus.wb_stb_o ? 4'hF : 4'h0)) sel_viol++;
            prev_ack = bus.wb_ack_i && bus.wb_stb_o;
            prev_stb = bus.wb_stb_o;
            prev_adr = bus.wb_adr_o;
            prev_dat = bus.wb_dat_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input byte_q_t b, input int i);
        return (32'(b[4*i]) << 24) | (32'(b[4*i+1]) << 16) | (32'(b[4*i+2]) << 8) | 32'(b[4*i+3]);
    endfunction

    function automatic logic [31:0] exp_adr(input logic [31:0] base, input int i);
        return (base - (base % 32'd4)) + 32'(4 * i);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_cyc"},   32'(bus.wb_cyc_o), 32'd0);
        check({tag, "_stb"},   32'(bus.wb_stb_o), 32'd0);
        check({tag, "_we"},    32'(bus.wb_we_o), 32'd0);
        check({tag, "_sel"},   32'(bus.wb_sel_o), 32'd0);
        check({tag, "_adr"},   bus.wb_adr_o, 32'd0);
        check({tag, "_dat"},   bus.wb_dat_o, 32'd0);
        check({tag, "_rdy"},   32'(bus.rx_ready_o), 32'd0);
        check({tag, "_busy"},  32'(busy_o), 32'd0);
        check({tag, "_done"},  32'(done_o), 32'd0);
        check({tag, "_err"},   32'(err_o), 32'd0);
        check({tag, "_words"}, 32'(words_o), 32'd0);
    endtask

    task automatic start_xfer(input logic [31:0] base, input int len);
        @(negedge clk);
        start_i    = 1'b1;
        base_adr_i = base;
        len_i      = 16'(len);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_bytes(input byte_q_t b, input bit rnd);
        int  i = 0;
        int  budget = 0;
        bit  acc;
        @(negedge clk);
        while (i < b.size() && budget < 3000) begin
            if (rnd && $urandom_range(0, 2) == 0) begin
                bus.rx_valid_i = 1'b0;
            end else begin
                bus.rx_valid_i = 1'b1;
                bus.rx_data_i  = b[i];
            end
            acc = bus.rx_valid_i && bus.rx_ready_o;
            @(negedge clk);
            budget++;
            if (acc) i++;
        end
        bus.rx_valid_i = 1'b0;
        check("bytes_accepted", 32'(i), 32'(b.size()));
    endtask

    task automatic wait_idle();
        int budget = 0;
        while (busy_o && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        check("idle_reached", 32'(busy_o), 32'd0);
    endtask

    task automatic run_xfer(input logic [31:0] base, input int len, input byte_q_t b, input bit rnd);
        int d0 = done_cnt;
        int e0 = err_cnt;
        wr_q.delete();
        start_xfer(base, len);
        send_bytes(b, rnd);
        wait_idle();
        @(negedge clk);
        check("write_count", 32'(wr_q.size()), 32'(len));
        for (int i = 0; i < len && i < wr_q.size(); i++) begin
            check($sformatf("adr[%0d]", i), wr_q[i].adr, exp_adr(base, i));
            check($sformatf("dat[%0d]", i), wr_q[i].dat, exp_word(b, i));
            check($sformatf("readback[%0d]", i), mem[exp_adr(base, i)], exp_word(b, i));
        end
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("err_pulses", 32'(err_cnt - e0), 32'd0);
        check("words_final", 32'(words_o), 32'(len));
    endtask

    initial begin
        vec_t    tbl[4];
        byte_q_t b;
        int      s0, b0, d0, e0;

        tbl[0] = '{base: 32'h0000_1000, len: 3, exp_first: 32'h0000_1000, exp_last: 32'h0000_1008};
        tbl[1] = '{base: 32'hFFFF_FFFC, len: 2, exp_first: 32'hFFFF_FFFC, exp_last: 32'h0000_0000};
        tbl[2] = '{base: 32'h0000_0203, len: 1, exp_first: 32'h0000_0200, exp_last: 32'h0000_0200};
        tbl[3] = '{base: 32'hFFFF_FFF9, len: 3, exp_first: 32'hFFFF_FFF8, exp_last: 32'h0000_0000};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_i = 1'b0;
        @(negedge clk);

        // Directed: base 0x100, len 2, back-to-back bytes, one-cycle RAM.
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        s0 = stb_cyc;
        run_xfer(32'h100, 2, b, 1'b0);
        if (wr_q.size() == 2) begin
            check("dir_w0", wr_q[0].dat, 32'h1122_3344);
            check("dir_a0", wr_q[0].adr, 32'h0000_0100);
            check("dir_w1", wr_q[1].dat, 32'h5566_7788);
            check("dir_a1", wr_q[1].adr, 32'h0000_0104);
        end else begin
            check("dir_size", 32'(wr_q.size()), 32'd2);
        end
        check("dir_stb_cycles", 32'(stb_cyc - s0), 32'd4);

        // Table-driven address cases including wrap and unaligned base.
        for (int t = 0; t < 4; t++) begin
            b.delete();
            for (int k = 0; k < 4 * tbl[t].len; k++) b.push_back(8'($urandom));
            run_xfer(tbl[t].base, tbl[t].len, b, 1'b0);
            if (wr_q.size() > 0) begin
                check($sformatf("tbl%0d_first", t), wr_q[0].adr, tbl[t].exp_first);
                check($sformatf("tbl%0d_last", t), wr_q[wr_q.size()-1].adr, tbl[t].exp_last);
            end else begin
                check($sformatf("tbl%0d_nowrites", t), 32'(wr_q.size()), 32'(tbl[t].len));
            end
        end

        // Random valid gaps and random ack latency.
        slave_rand = 1'b1;
        for (int t = 0; t < 6; t++) begin
            int len = int'($urandom_range(1, 6));
            b.delete();
            for (int k = 0; k < 4 * len; k++) b.push_back(8'($urandom));
            run_xfer($urandom, len, b, 1'b1);
        end
        slave_rand = 1'b0;
        cur_delay  = 0;

        // Zero length: done only, no bus activity, never busy.
        s0 = stb_cyc; b0 = busy_cyc; d0 = done_cnt;
        wr_q.delete();
        start_xfer(32'h700, 0);
        repeat (3) @(negedge clk);
        check("len0_done", 32'(done_cnt - d0), 32'd1);
        check("len0_stb", 32'(stb_cyc - s0), 32'd0);
        check("len0_busy", 32'(busy_cyc - b0), 32'd0);
        check("len0_writes", 32'(wr_q.size()), 32'd0);

        // Silent slave: timeout after exactly 8 WRITE cycles.
        slave_mute = 1'b1;
        s0 = stb_cyc; d0 = done_cnt; e0 = err_cnt;
        wr_q.delete();
        start_xfer(32'h40, 2);
        b = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_bytes(b, 1'b0);
        wait_idle();
        @(negedge clk);
        check("to_err", 32'(err_cnt - e0), 32'd1);
        check("to_stb_cycles", 32'(stb_cyc - s0), 32'd8);
        check("to_done", 32'(done_cnt - d0), 32'd0);
        check("to_cyc", 32'(bus.wb_cyc_o), 32'd0);
        check("to_words", 32'(words_o), 32'd0);
        slave_mute = 1'b0;

        // Abort after two bytes; stale bytes must not leak into the next word.
        d0 = done_cnt; e0 = err_cnt;
        wr_q.delete();
        start_xfer(32'h500, 3);
        b = '{8'h5A, 8'hC3};
        send_bytes(b, 1'b0);
        @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_rdy", 32'(bus.rx_ready_o), 32'd0);
        check("abort_writes", 32'(wr_q.size()), 32'd0);
        check("abort_done", 32'(done_cnt - d0), 32'd0);
        check("abort_err", 32'(err_cnt - e0), 32'd0);
        b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_xfer(32'h600, 1, b, 1'b0);
        if (wr_q.size() > 0) check("abort_next_word", wr_q[0].dat, 32'hAABB_CCDD);

        // Reset asserted while a write is outstanding.
        slave_mute = 1'b1;
        d0 = done_cnt;
        wr_q.delete();
        start_xfer(32'h300, 1);
        b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_bytes(b, 1'b0);
        @(negedge clk);
        check("rst_pre_stb", 32'(bus.wb_stb_o), 32'd1);
        #2 rst_i = 1'b1;
        #1 check_all_zero("midrst");
        @(negedge clk);
        check("midrst_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_writes", 32'(wr_q.size()), 32'd0);
        rst_i = 1'b0;
        slave_mute = 1'b0;
        @(negedge clk);

        check("gap_violations", 32'(gap_viol), 32'd0);
        check("stability_violations", 32'(stab_viol), 32'd0);
        check("ctrl_violations", 32'(sel_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
